cim_seq_ctrl: RTL and testbench



---
 rtl/cim_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_cim_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_seq_ctrl.sv
// Sequencing controller for the tsmccim16x8x11m1 compute-in-memory macro: weight stream load,
// all-row compute, single-word readback, with a first-word-fall-through result FIFO and credit-gated issue.
module cim_seq_ctrl #(
  parameter int CORE_NUM      = 16,
  parameter int XIN_BIT_WIDTH = 11,
  parameter int MEM_BIT_WIDTH = 8,
  parameter int MEM_ADR_WIDTH = 2,
  parameter int MAC_LAT       = 2,
  parameter int OUT_W         = XIN_BIT_WIDTH + MEM_BIT_WIDTH + $clog2(CORE_NUM)
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [1:0]                        cmd_op,
  input  logic [$clog2(CORE_NUM)-1:0]       cmd_bank,
  input  logic [MEM_ADR_WIDTH-1:0]          cmd_adr,
  input  logic [CORE_NUM*XIN_BIT_WIDTH-1:0] cmd_xin,
  input  logic                              wdat_valid,
  output logic                              wdat_ready,
  input  logic [MEM_BIT_WIDTH-1:0]          wdat,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [OUT_W-1:0]                  res_data,
  output logic [MEM_ADR_WIDTH-1:0]          res_row,
  output logic                              res_last,
  output logic                              busy,
  output logic                              err_op,
  output logic                              CIM_NRST,
  output logic                              CIM_ENCB,
  output logic                              CIM_WEB,
  output logic                              CIM_REB,
  output logic [$clog2(CORE_NUM)-1:0]       CIM_BANKA,
  output logic [$clog2(CORE_NUM)-1:0]       CIM_BANKB,
  output logic [MEM_ADR_WIDTH-1:0]          CIM_ADRA,
  output logic [MEM_ADR_WIDTH-1:0]          CIM_ADRB,
  output logic [MEM_BIT_WIDTH-1:0]          CIM_D,
  output logic [CORE_NUM*XIN_BIT_WIDTH-1:0] CIM_XIN,
  input  logic [OUT_W-1:0]                  CIM_Q
);
  localparam int ROWS   = 1 << MEM_ADR_WIDTH;
  localparam int NWORDS = CORE_NUM * ROWS;
  localparam int IW     = $clog2(NWORDS);
  localparam int BW     = $clog2(CORE_NUM);
  localparam int ICW    = MEM_ADR_WIDTH + 1;
  localparam int FCW    = $clog2(ROWS + 1);
  localparam int CW     = $clog2(ROWS + MAC_LAT + 1);
  localparam int XW     = CORE_NUM * XIN_BIT_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, COMP, READ} state_e;

  typedef struct packed {
    logic [MEM_ADR_WIDTH-1:0] row;
    logic                     last;
    logic                     rd;
  } tag_t;

  typedef struct packed {
    logic [OUT_W-1:0]         data;
    logic [MEM_ADR_WIDTH-1:0] row;
    logic                     last;
  } res_t;

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     web_q, web_d;
  logic [MEM_BIT_WIDTH-1:0] d_q, d_d;
  logic [BW-1:0]            banka_q, banka_d;
  logic [MEM_ADR_WIDTH-1:0] adra_q, adra_d;
  logic [XW-1:0]            xin_q, xin_d;
  logic [BW-1:0]            rd_bank_q, rd_bank_d;
  logic [MEM_ADR_WIDTH-1:0] rd_adr_q, rd_adr_d;
  logic [ICW-1:0]           iss_cnt_q, iss_cnt_d;
  logic                     err_q, err_d;
  logic                     nrst_q;

  logic [MAC_LAT:1]         vld_pipe_q, vld_pipe_d;
  tag_t [MAC_LAT:1]         tag_pipe_q, tag_pipe_d;

  res_t                     fifo_mem_q [ROWS];
  logic [MEM_ADR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0]           fifo_cnt_q, fifo_cnt_d;

  logic                     issue, enc_n, reb_n, credit_ok, drain_ok, push, pop;
  logic [CW-1:0]            inflight;
  logic [BW-1:0]            bankb;
  logic [MEM_ADR_WIDTH-1:0] adrb;
  tag_t                     iss_tag;
  res_t                     push_ent, res_ent;

  // Credits count FIFO occupancy plus every capture still in the pipe, so a push always has room.
  always_comb begin
    inflight = '0;
    drain_ok = 1'b1;
    for (int k = 1; k <= MAC_LAT; k++) inflight = inflight + CW'(vld_pipe_q[k]);
    for (int k = 1; k < MAC_LAT; k++) if (vld_pipe_q[k]) drain_ok = 1'b0;
    credit_ok = (CW'(fifo_cnt_q) + inflight) < CW'(ROWS);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    web_d     = 1'b1;
    d_d       = d_q;
    banka_d   = banka_q;
    adra_d    = adra_q;
    xin_d     = xin_q;
    rd_bank_d = rd_bank_q;
    rd_adr_d  = rd_adr_q;
    iss_cnt_d = iss_cnt_q;
    err_d     = 1'b0;
    issue     = 1'b0;
    enc_n     = 1'b1;
    reb_n     = 1'b1;
    bankb     = '0;
    adrb      = '0;
    iss_tag   = '0;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        unique case (cmd_op)
          2'b00: begin state_d = LOAD; idx_d = '0; end
          2'b01: begin state_d = COMP; xin_d = cmd_xin; iss_cnt_d = '0; end
          2'b10: begin
            state_d   = READ;
            rd_bank_d = cmd_bank;
            rd_adr_d  = cmd_adr;
            iss_cnt_d = '0;
          end
          default: err_d = 1'b1;
        endcase
      end
      LOAD: if (wdat_valid) begin
        web_d   = 1'b0;
        d_d     = wdat;
        banka_d = idx_q[IW-1:MEM_ADR_WIDTH];
        adra_d  = idx_q[MEM_ADR_WIDTH-1:0];
        if (idx_q == IW'(NWORDS - 1)) state_d = IDLE;
        else                          idx_d   = idx_q + 1'b1;
      end
      COMP: begin
        if (iss_cnt_q < ICW'(ROWS) && credit_ok) begin
          issue        = 1'b1;
          enc_n        = 1'b0;
          adrb         = iss_cnt_q[MEM_ADR_WIDTH-1:0];
          iss_tag.row  = iss_cnt_q[MEM_ADR_WIDTH-1:0];
          iss_tag.last = (iss_cnt_q == ICW'(ROWS - 1));
          iss_cnt_d    = iss_cnt_q + 1'b1;
        end else if (iss_cnt_q == ICW'(ROWS) && drain_ok) begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (iss_cnt_q == '0 && credit_ok) begin
          issue        = 1'b1;
          reb_n        = 1'b0;
          bankb        = rd_bank_q;
          adrb         = rd_adr_q;
          iss_tag.row  = rd_adr_q;
          iss_tag.last = 1'b1;
          iss_tag.rd   = 1'b1;
          iss_cnt_d    = ICW'(1);
        end else if (iss_cnt_q != '0 && drain_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_pipe_d    = '0;
    tag_pipe_d    = '0;
    vld_pipe_d[1] = issue;
    tag_pipe_d[1] = iss_tag;
    for (int k = 2; k <= MAC_LAT; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      tag_pipe_d[k] = tag_pipe_q[k-1];
    end
  end

  assign push          = vld_pipe_q[MAC_LAT];
  assign pop           = res_valid & res_ready;
  assign push_ent.data = tag_pipe_q[MAC_LAT].rd
                       ? {{(OUT_W-MEM_BIT_WIDTH){1'b0}}, CIM_Q[MEM_BIT_WIDTH-1:0]} : CIM_Q;
  assign push_ent.row  = tag_pipe_q[MAC_LAT].row;
  assign push_ent.last = tag_pipe_q[MAC_LAT].last;

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      web_q      <= 1'b1;
      d_q        <= '0;
      banka_q    <= '0;
      adra_q     <= '0;
      xin_q      <= '0;
      rd_bank_q  <= '0;
      rd_adr_q   <= '0;
      iss_cnt_q  <= '0;
      err_q      <= 1'b0;
      nrst_q     <= 1'b0;
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      web_q      <= web_d;
      d_q        <= d_d;
      banka_q    <= banka_d;
      adra_q     <= adra_d;
      xin_q      <= xin_d;
      rd_bank_q  <= rd_bank_d;
      rd_adr_q   <= rd_adr_d;
      iss_cnt_q  <= iss_cnt_d;
      err_q      <= err_d;
      nrst_q     <= 1'b1;
      vld_pipe_q <= vld_pipe_d;
      tag_pipe_q <= tag_pipe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_ent;
  end

  assign res_ent    = fifo_mem_q[rd_ptr_q];
  assign res_valid  = (fifo_cnt_q != '0);
  assign res_data   = res_ent.data;
  assign res_row    = res_ent.row;
  assign res_last   = res_ent.last;
  assign cmd_ready  = (state_q == IDLE);
  assign wdat_ready = (state_q == LOAD);
  assign busy       = (state_q != IDLE);
  assign err_op     = err_q;
  assign CIM_NRST   = nrst_q;
  assign CIM_ENCB   = enc_n;
  assign CIM_REB    = reb_n;
  assign CIM_WEB    = web_q;
  assign CIM_BANKA  = banka_q;
  assign CIM_ADRA   = adra_q;
  assign CIM_D      = d_q;
  assign CIM_XIN    = xin_q;
  assign CIM_BANKB  = bankb;
  assign CIM_ADRB   = adrb;
endmodule

// File: tb/tb_cim_seq_ctrl.sv
// Bench for cim_seq_ctrl: behavioural macro model plus a result scoreboard fed when commands are driven.
module tb_cim_seq_ctrl;
  localparam int CORE_NUM = 16;
  localparam int XIN      = 11;
  localparam int MEMW     = 8;
  localparam int ADRW     = 2;
  localparam int MAC_LAT  = 2;
  localparam int ROWS     = 4;
  localparam int OUT_W    = 23;
  localparam int BW       = 4;
  localparam int XW       = CORE_NUM * XIN;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [ADRW-1:0]  row;
    logic             last;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic cmd_valid, cmd_ready, wdat_valid, wdat_ready, res_valid, res_ready, res_last, busy, err_op;
  logic [1:0] cmd_op;
  logic [BW-1:0] cmd_bank, CIM_BANKA, CIM_BANKB;
  logic [ADRW-1:0] cmd_adr, res_row, CIM_ADRA, CIM_ADRB;
  logic [XW-1:0] cmd_xin, CIM_XIN;
  logic [MEMW-1:0] wdat, CIM_D;
  logic [OUT_W-1:0] res_data, CIM_Q;
  logic CIM_NRST, CIM_ENCB, CIM_WEB, CIM_REB;

  int n_vec = 0, n_err = 0, cyc = 0;
  int enc_cnt = 0, web_cnt = 0, reb_cnt = 0, mon_nl;
  int tb_w [CORE_NUM][ROWS];
  logic [MEMW-1:0] mem [CORE_NUM][ROWS];
  logic [OUT_W-1:0] qp [1:MAC_LAT];
  exp_t sb[$];
  exp_t e_pop;

  cim_seq_ctrl #(.CORE_NUM(CORE_NUM), .XIN_BIT_WIDTH(XIN), .MEM_BIT_WIDTH(MEMW),
                 .MEM_ADR_WIDTH(ADRW), .MAC_LAT(MAC_LAT), .OUT_W(OUT_W)) dut (
    .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_bank(cmd_bank), .cmd_adr(cmd_adr), .cmd_xin(cmd_xin), .wdat_valid(wdat_valid),
    .wdat_ready(wdat_ready), .wdat(wdat), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_row(res_row), .res_last(res_last), .busy(busy), .err_op(err_op),
    .CIM_NRST(CIM_NRST), .CIM_ENCB(CIM_ENCB), .CIM_WEB(CIM_WEB), .CIM_REB(CIM_REB),
    .CIM_BANKA(CIM_BANKA), .CIM_BANKB(CIM_BANKB), .CIM_ADRA(CIM_ADRA), .CIM_ADRB(CIM_ADRB),
    .CIM_D(CIM_D), .CIM_XIN(CIM_XIN), .CIM_Q(CIM_Q));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Macro model: write on WEB low, MAC or readback sampled at the issue edge, result after MAC_LAT.
  function automatic logic [OUT_W-1:0] macro_now();
    int s;
    s = 0;
    if (!CIM_ENCB) begin
      for (int c = 0; c < CORE_NUM; c++)
        s += int'(CIM_XIN[c*XIN +: XIN]) * int'(mem[c][CIM_ADRB]);
    end else if (!CIM_REB) begin
      s = int'(mem[CIM_BANKB][CIM_ADRB]);
    end
    return OUT_W'(s);
  endfunction

  always @(posedge CLK) begin
    if (!CIM_WEB) mem[CIM_BANKA][CIM_ADRA] <= CIM_D;
    qp[1] <= macro_now();
    for (int k = 2; k <= MAC_LAT; k++) qp[k] <= qp[k-1];
  end
  assign CIM_Q = qp[MAC_LAT];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int exp_mac(input logic [XW-1:0] x, input int r);
    int s;
    s = 0;
    for (int c = 0; c < CORE_NUM; c++) s += int'(x[c*XIN +: XIN]) * tb_w[c][r];
    return s;
  endfunction

  task automatic push_comp(input logic [XW-1:0] x);
    for (int r = 0; r < ROWS; r++)
      sb.push_back('{data: OUT_W'(exp_mac(x, r)), row: ADRW'(r), last: (r == ROWS - 1)});
  endtask

  always begin
    @(negedge CLK);
    if (!CIM_ENCB) enc_cnt++;
    if (!CIM_WEB)  web_cnt++;
    if (!CIM_REB)  reb_cnt++;
    mon_nl = int'(!CIM_ENCB) + int'(!CIM_WEB) + int'(!CIM_REB);
    if (mon_nl > 0) chk("enable_onehot", 32'(mon_nl), 1);
    if (res_valid && res_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 1);
      else begin
        e_pop = sb.pop_front();
        chk("res_data", 32'(res_data), 32'(e_pop.data));
        chk("res_row",  32'(res_row),  32'(e_pop.row));
        chk("res_last", 32'(res_last), 32'(e_pop.last));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [BW-1:0] bank,
                          input logic [ADRW-1:0] adr, input logic [XW-1:0] x, output int t);
    int k;
    cmd_valid = 1'b1; cmd_op = op; cmd_bank = bank; cmd_adr = adr; cmd_xin = x;
    k = 0;
    while (!cmd_ready && k < 50) begin step(); k++; end
    chk("cmd_ready", 32'(cmd_ready), 1);
    t = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, k, e0, w0, r0;
    logic [XW-1:0] x;
    cmd_valid = 0; cmd_op = 0; cmd_bank = 0; cmd_adr = 0; cmd_xin = '0;
    wdat_valid = 0; wdat = 0; res_ready = 1;
    RST = 1;
    repeat (3) step();
    chk("rst_web",  32'(CIM_WEB), 1);
    chk("rst_encb", 32'(CIM_ENCB), 1);
    chk("rst_reb",  32'(CIM_REB), 1);
    chk("rst_nrst", 32'(CIM_NRST), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rv",   32'(res_valid), 0);
    chk("rst_err",  32'(err_op), 0);
    chk("rst_wrdy", 32'(wdat_ready), 0);
    chk("rst_bus",  32'({CIM_BANKA, CIM_ADRA, CIM_D, CIM_BANKB, CIM_ADRB}), 0);
    RST = 0;
    step();
    chk("nrst_rel", 32'(CIM_NRST), 1);

    // Partial load, then reset lands while words are still streaming
    send_cmd(2'b00, '0, '0, '0, t);
    for (int i = 0; i < 10; i++) begin wdat_valid = 1; wdat = MEMW'(i); step(); end
    wdat = 8'd10; RST = 1;
    step();
    chk("mid_rst_web",  32'(CIM_WEB), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_crdy", 32'(cmd_ready), 1);
    chk("mid_rst_rv",   32'(res_valid), 0);
    chk("mid_rst_nrst", 32'(CIM_NRST), 0);
    RST = 0; wdat_valid = 0;
    step();

    // Full load, wdat = word index
    w0 = web_cnt;
    send_cmd(2'b00, '0, '0, '0, t);
    chk("load_wrdy", 32'(wdat_ready), 1);
    for (int i = 0; i < CORE_NUM * ROWS; i++) begin
      wdat_valid = 1; wdat = MEMW'(i); tb_w[i / ROWS][i % ROWS] = i;
      step();
      if (i == 5) begin
        chk("w5_web",   32'(CIM_WEB), 0);
        chk("w5_banka", 32'(CIM_BANKA), 1);
        chk("w5_adra",  32'(CIM_ADRA), 1);
        chk("w5_d",     32'(CIM_D), 5);
      end
    end
    wdat_valid = 0;
    chk("load_last_web",  32'(CIM_WEB), 0);
    chk("load_end_crdy",  32'(cmd_ready), 1);
    step();
    chk("load_crdy_after", 32'(cmd_ready), 1);
    chk("load_pulses",     32'(web_cnt - w0), 64);

    // Compute, all activations 1, empty FIFO
    for (int c = 0; c < CORE_NUM; c++) x[c*XIN +: XIN] = XIN'(1);
    push_comp(x);
    e0 = enc_cnt;
    send_cmd(2'b01, '0, '0, x, t);
    @(negedge CLK);
    k = 0;
    while (!res_valid && k < 20) begin @(negedge CLK); k++; end
    chk("first_res_lat", 32'(cyc - t), 4);
    k = 0;
    while (busy && k < 40) begin @(negedge CLK); k++; end
    chk("busy_fall", 32'(cyc - t), 7);
    step();
    chk("comp_encb", 32'(enc_cnt - e0), 4);
    chk("comp_sb_drained", 32'(sb.size()), 0);

    // Compute with output stalled
    res_ready = 0;
    for (int c = 0; c < CORE_NUM; c++) x[c*XIN +: XIN] = XIN'(c + 1);
    push_comp(x);
    e0 = enc_cnt;
    send_cmd(2'b01, '0, '0, x, t);
    repeat (19) step();
    chk("stall_encb", 32'(enc_cnt - e0), 4);
    chk("stall_rv",   32'(res_valid), 1);
    chk("stall_busy", 32'(busy), 0);
    chk("stall_held", 32'(sb.size()), 4);
    res_ready = 1;
    repeat (6) step();
    chk("stall_drained", 32'(sb.size()), 0);

    // Random activations with random backpressure
    for (int c = 0; c < CORE_NUM; c++) x[c*XIN +: XIN] = XIN'($urandom_range(0, 2047));
    push_comp(x);
    e0 = enc_cnt;
    send_cmd(2'b01, '0, '0, x, t);
    for (int i = 0; i < 40; i++) begin res_ready = 1'($urandom_range(0, 1)); step(); end
    res_ready = 1;
    repeat (6) step();
    chk("rand_encb",    32'(enc_cnt - e0), 4);
    chk("rand_drained", 32'(sb.size()), 0);
    chk("rand_busy",    32'(busy), 0);

    // Readbacks: top corner and bottom corner
    sb.push_back('{data: OUT_W'(63), row: 2'd3, last: 1'b1});
    r0 = reb_cnt; e0 = enc_cnt; w0 = web_cnt;
    send_cmd(2'b10, 4'd15, 2'd3, '0, t);
    repeat (8) step();
    chk("rb_reb",    32'(reb_cnt - r0), 1);
    chk("rb_others", 32'((enc_cnt - e0) + (web_cnt - w0)), 0);
    chk("rb_drained", 32'(sb.size()), 0);
    sb.push_back('{data: OUT_W'(0), row: 2'd0, last: 1'b1});
    send_cmd(2'b10, 4'd0, 2'd0, '0, t);
    repeat (8) step();
    chk("rb0_drained", 32'(sb.size()), 0);

    // Illegal opcode
    r0 = reb_cnt; e0 = enc_cnt; w0 = web_cnt;
    send_cmd(2'b11, '0, '0, '0, t);
    chk("ill_err",  32'(err_op), 1);
    chk("ill_crdy", 32'(cmd_ready), 1);
    chk("ill_busy", 32'(busy), 0);
    step();
    chk("ill_err_pulse", 32'(err_op), 0);
    chk("ill_no_enable", 32'((reb_cnt - r0) + (enc_cnt - e0) + (web_cnt - w0)), 0);

    // Reset while compute results sit in the FIFO
    res_ready = 0;
    push_comp(x);
    send_cmd(2'b01, '0, '0, x, t);
    repeat (3) step();
    chk("rc_pre_rv", 32'(res_valid), 1);
    RST = 1;
    step();
    chk("rc_rv",   32'(res_valid), 0);
    chk("rc_encb", 32'(CIM_ENCB), 1);
    chk("rc_nrst", 32'(CIM_NRST), 0);
    chk("rc_busy", 32'(busy), 0);
    RST = 0;
    sb.delete();
    repeat (5) step();
    chk("rc_no_stale", 32'(res_valid), 0);
    res_ready = 1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
